// File: rtl/sprite_mem_responder_if.sv
// Bus bundle between pixel_loader (read strobe side), the host pixel writer and
// the sprite memory responder.
interface sprite_mem_responder_if;
    logic        MEM_CLK;
    logic [15:0] MEM_ADDR;
    logic [2:0]  MEM_SEL;
    logic [47:0] DATA_OUT;
    logic        DATA_VALID;
    logic        WR_VALID;
    logic        WR_READY;
    logic [2:0]  WR_SEL;
    logic [15:0] WR_ADDR;
    logic [23:0] WR_PIXEL;

    modport master (
        output MEM_CLK, MEM_ADDR, MEM_SEL, WR_VALID, WR_SEL, WR_ADDR, WR_PIXEL,
        input  DATA_OUT, DATA_VALID, WR_READY
    );

    modport slave (
        input  MEM_CLK, MEM_ADDR, MEM_SEL, WR_VALID, WR_SEL, WR_ADDR, WR_PIXEL,
        output DATA_OUT, DATA_VALID, WR_READY
    );
endinterface

// File: rtl/sprite_mem_responder.sv
// Sprite memory: 8 banks of 48-bit two-pixel words, read by MEM_CLK rising edges
// with a fixed 2-cycle latency, written one pixel at a time by the host.
//
// state    | meaning
// ST_CLEAR | sweeping {bank, word} and zeroing memory; reads return 0, writes stalled
// ST_IDLE  | normal service of reads and host writes
module sprite_mem_responder #(
    parameter int ADDR_BITS = 8
) (
    input  logic                         CLK,
    input  logic                         RESET,
    sprite_mem_responder_if.slave        io_bus
);
    localparam int IDX_W   = ADDR_BITS + 3;
    localparam int N_WORDS = 8 << ADDR_BITS;
    localparam logic [IDX_W-1:0] CLR_LAST = '1;
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_clr_cnt;
    logic             r_mclk_q;

    logic [23:0]      r_mem_hi [N_WORDS];
    logic [23:0]      r_mem_lo [N_WORDS];

    logic             r_rd_pend;
    logic [IDX_W-1:0] r_rd_idx;
    logic             r_rd_zero;
    logic             r_rd_vld2;
    logic [47:0]      r_rd_data;
    logic [47:0]      r_data_out;
    logic             r_data_valid;

    logic             w_rd_edge;
    logic             w_rd_in_range;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_wr_in_range;
    logic [IDX_W-1:0] w_wr_idx;
    logic             w_wr_ready;
    logic             w_wr_fire;

    assign w_rd_edge     = io_bus.MEM_CLK & ~r_mclk_q;
    assign w_rd_in_range = (io_bus.MEM_ADDR[15:ADDR_BITS] == '0);
    assign w_rd_idx      = {io_bus.MEM_SEL, io_bus.MEM_ADDR[ADDR_BITS-1:0]};
    assign w_wr_in_range = (io_bus.WR_ADDR[15:ADDR_BITS+1] == '0);
    assign w_wr_idx      = {io_bus.WR_SEL, io_bus.WR_ADDR[ADDR_BITS:1]};

    // Reads win over writes; a reset edge must never complete a handshake.
    assign w_wr_ready    = (r_state == ST_IDLE) & ~w_rd_edge & ~RESET;
    assign w_wr_fire     = io_bus.WR_VALID & w_wr_ready;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= ST_CLEAR;
            r_clr_cnt    <= '0;
            r_mclk_q     <= 1'b1;
            r_rd_pend    <= 1'b0;
            r_rd_idx     <= '0;
            r_rd_zero    <= 1'b0;
            r_rd_vld2    <= 1'b0;
            r_rd_data    <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_mclk_q <= io_bus.MEM_CLK;

            if (r_state == ST_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + IDX_ONE;
                if (r_clr_cnt == CLR_LAST) begin
                    r_state <= ST_IDLE;
                end
            end

            r_rd_pend <= w_rd_edge;
            if (w_rd_edge) begin
                r_rd_idx  <= w_rd_idx;
                r_rd_zero <= ~w_rd_in_range | (r_state == ST_CLEAR);
            end

            r_rd_vld2 <= r_rd_pend;
            if (r_rd_pend) begin
                r_rd_data <= r_rd_zero ? 48'h0 : {r_mem_hi[r_rd_idx], r_mem_lo[r_rd_idx]};
            end

            r_data_valid <= r_rd_vld2;
            if (r_rd_vld2) begin
                r_data_out <= r_rd_data;
            end
        end
    end

    // Clear and host writes are mutually exclusive since WR_READY is low in ST_CLEAR.
    always_ff @(posedge CLK) begin
        if ((r_state == ST_CLEAR) && !RESET) begin
            r_mem_hi[r_clr_cnt] <= '0;
            r_mem_lo[r_clr_cnt] <= '0;
        end else if (w_wr_fire && w_wr_in_range) begin
            if (io_bus.WR_ADDR[0]) begin
                r_mem_lo[w_wr_idx] <= io_bus.WR_PIXEL;
            end else begin
                r_mem_hi[w_wr_idx] <= io_bus.WR_PIXEL;
            end
        end
    end

    assign io_bus.DATA_OUT   = r_data_out;
    assign io_bus.DATA_VALID = r_data_valid;
    assign io_bus.WR_READY   = w_wr_ready;
endmodule

// File: tb/tb_sprite_mem_responder.sv
// Bench for sprite_mem_responder (ADDR_BITS = 4): fixed vector table, hand-written
// corner sequences and random traffic against a pixel-addressed memory model.
module tb_sprite_mem_responder;
    localparam int AB = 4;

    logic CLK = 1'b0;
    logic RESET;

    sprite_mem_responder_if bus();

    sprite_mem_responder #(.ADDR_BITS(AB)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .io_bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: pixels addressed exactly as the host sees them; word w = {pixel 2w, pixel 2w+1}.
    logic [23:0] pix [8][32];

    typedef struct {
        bit          is_wr;
        logic [2:0]  sel;
        logic [15:0] addr;
        logic [23:0] pixel;
        logic [47:0] exp;
    } vec_t;

    vec_t tbl [12];

    task automatic tick();
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int b = 0; b < 8; b++)
            for (int p = 0; p < 32; p++)
                pix[b][p] = 24'h0;
    endfunction

    function automatic logic [47:0] model_word(input logic [2:0] b, input logic [15:0] w);
        if (w > 16'd15) return 48'h0;
        return {pix[b][{w[3:0], 1'b0}], pix[b][{w[3:0], 1'b1}]};
    endfunction

    task automatic do_read(input logic [2:0] sel, input logic [15:0] addr,
                           input logic [47:0] exp, input string name);
        int lat;
        bus.MEM_CLK  = 1'b1;
        bus.MEM_SEL  = sel;
        bus.MEM_ADDR = addr;
        tick();
        bus.MEM_CLK = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.DATA_VALID && lat < 6);
        check({name, " latency"}, 48'(lat), 48'd2);
        check({name, " data"}, bus.DATA_OUT, exp);
        tick();
        check({name, " valid width"}, 48'(bus.DATA_VALID), 48'd0);
    endtask

    task automatic do_write(input logic [2:0] sel, input logic [15:0] addr,
                            input logic [23:0] p, input string name);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        bus.WR_VALID = 1'b1;
        bus.WR_SEL   = sel;
        bus.WR_ADDR  = addr;
        bus.WR_PIXEL = p;
        while (!acc && n < 8) begin
            #1;
            acc = bus.WR_READY;
            tick();
            n++;
        end
        bus.WR_VALID = 1'b0;
        check({name, " accept"}, 48'(acc), 48'd1);
        if (acc && addr < 16'd32) pix[sel][addr[4:0]] = p;
    endtask

    task automatic wait_ready(input int start, input string name);
        while (!bus.WR_READY && (cyc - start) < 400) tick();
        check({name, " clear length"}, 48'(cyc - start), 48'd128);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rst_cyc;
        int          pc;
        int          pcyc [8];
        logic [47:0] pdat [8];
        logic [47:0] old_w;
        logic [2:0]  s;
        logic [15:0] a;
        logic [23:0] p;

        tbl[0]  = '{1'b0, 3'd7, 16'd15,     24'h0,      48'h0};
        tbl[1]  = '{1'b1, 3'd2, 16'd6,      24'hFF0000, 48'h0};
        tbl[2]  = '{1'b1, 3'd2, 16'd7,      24'h00FF00, 48'h0};
        tbl[3]  = '{1'b0, 3'd2, 16'd3,      24'h0,      48'hFF000000FF00};
        tbl[4]  = '{1'b0, 3'd3, 16'd3,      24'h0,      48'h0};
        tbl[5]  = '{1'b0, 3'd2, 16'h0010,   24'h0,      48'h0};
        tbl[6]  = '{1'b1, 3'd2, 16'h0020,   24'hABCDEF, 48'h0};
        tbl[7]  = '{1'b0, 3'd2, 16'd0,      24'h0,      48'h0};
        tbl[8]  = '{1'b0, 3'd2, 16'd3,      24'h0,      48'hFF000000FF00};
        tbl[9]  = '{1'b1, 3'd2, 16'd0,      24'h13579B, 48'h0};
        tbl[10] = '{1'b0, 3'd2, 16'd0,      24'h0,      48'h13579B000000};
        tbl[11] = '{1'b0, 3'd2, 16'h8000,   24'h0,      48'h0};

        bus.MEM_CLK  = 1'b0;
        bus.MEM_ADDR = 16'h0;
        bus.MEM_SEL  = 3'd0;
        bus.WR_VALID = 1'b1;
        bus.WR_SEL   = 3'd1;
        bus.WR_ADDR  = 16'd4;
        bus.WR_PIXEL = 24'h123456;
        RESET        = 1'b1;
        model_clear();

        // Reset and clear, with a write held pending throughout
        tick();
        tick();
        check("reset DATA_OUT", bus.DATA_OUT, 48'h0);
        check("reset DATA_VALID", 48'(bus.DATA_VALID), 48'd0);
        check("reset WR_READY", 48'(bus.WR_READY), 48'd0);
        RESET   = 1'b0;
        rst_cyc = cyc;
        wait_ready(rst_cyc, "initial");
        bus.WR_VALID = 1'b0;

        foreach (tbl[i]) begin
            if (tbl[i].is_wr)
                do_write(tbl[i].sel, tbl[i].addr, tbl[i].pixel, $sformatf("tbl%0d wr", i));
            else
                do_read(tbl[i].sel, tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d rd", i));
        end

        // Collision: write held across a read strobe lands one cycle late
        old_w        = model_word(3'd4, 16'd4);
        bus.MEM_CLK  = 1'b1;
        bus.MEM_SEL  = 3'd4;
        bus.MEM_ADDR = 16'd4;
        bus.WR_VALID = 1'b1;
        bus.WR_SEL   = 3'd4;
        bus.WR_ADDR  = 16'd9;
        bus.WR_PIXEL = 24'hABCDEF;
        #1;
        check("collision ready in rd_edge", 48'(bus.WR_READY), 48'd0);
        tick();
        bus.MEM_CLK = 1'b0;
        #1;
        check("collision ready after", 48'(bus.WR_READY), 48'd1);
        tick();
        bus.WR_VALID = 1'b0;
        pix[4][9]    = 24'hABCDEF;
        bus.MEM_CLK  = 1'b1;
        tick();
        check("collision read1 valid", 48'(bus.DATA_VALID), 48'd1);
        check("collision read1 old data", bus.DATA_OUT, old_w);
        bus.MEM_CLK = 1'b0;
        tick();
        check("collision gap", 48'(bus.DATA_VALID), 48'd0);
        tick();
        check("collision read2 valid", 48'(bus.DATA_VALID), 48'd1);
        check("collision read2 new data", bus.DATA_OUT, model_word(3'd4, 16'd4));
        tick();

        // Random traffic
        for (int i = 0; i < 250; i++) begin
            s = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 9) == 0) a = 16'($urandom_range(32, 65535));
                else                           a = 16'($urandom_range(0, 31));
                p = 24'($urandom);
                do_write(s, a, p, "rand wr");
            end else begin
                if ($urandom_range(0, 9) == 0) a = 16'($urandom_range(16, 65535));
                else                           a = 16'($urandom_range(0, 15));
                do_read(s, a, model_word(s, a), "rand rd");
            end
        end

        // Strobe stream over bank 2 words 0..7
        for (int i = 0; i < 16; i++)
            do_write(3'd2, 16'(i), 24'(32'h0A0000 + i * 32'h010203), "stream fill");
        pc = 0;
        for (int j = 0; j < 8; j++) begin
            pcyc[j] = -1;
            pdat[j] = 48'hx;
        end
        bus.MEM_SEL = 3'd2;
        for (int c = 0; c < 22; c++) begin
            if (c < 15) begin
                bus.MEM_CLK  = (c % 2 == 0);
                bus.MEM_ADDR = 16'(c / 2);
            end else begin
                bus.MEM_CLK = 1'b1;
            end
            tick();
            if (bus.DATA_VALID) begin
                if (pc < 8) begin
                    pcyc[pc] = c;
                    pdat[pc] = bus.DATA_OUT;
                end
                pc++;
            end
        end
        check("stream pulse count", 48'(pc), 48'd8);
        for (int j = 0; j < 8; j++) begin
            check($sformatf("stream%0d timing", j), 48'(pcyc[j]), 48'(2 * j + 2));
            check($sformatf("stream%0d data", j), pdat[j], model_word(3'd2, 16'(j)));
        end
        bus.MEM_CLK = 1'b0;
        tick();

        // Reset one edge after a read strobe
        bus.MEM_CLK  = 1'b1;
        bus.MEM_SEL  = 3'd2;
        bus.MEM_ADDR = 16'd1;
        tick();
        RESET        = 1'b1;
        bus.WR_VALID = 1'b1;
        bus.WR_SEL   = 3'd2;
        bus.WR_ADDR  = 16'd2;
        bus.WR_PIXEL = 24'h777777;
        #1;
        check("ready while reset", 48'(bus.WR_READY), 48'd0);
        tick();
        RESET   = 1'b0;
        rst_cyc = cyc;
        model_clear();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("no valid after reset %0d", k), 48'(bus.DATA_VALID), 48'd0);
            tick();
        end
        check("DATA_OUT after reset", bus.DATA_OUT, 48'h0);
        bus.MEM_CLK = 1'b0;
        tick();
        do_read(3'd2, 16'd1, 48'h0, "read during clear");
        wait_ready(rst_cyc, "mid-read reset");
        bus.WR_VALID = 1'b0;
        do_read(3'd2, 16'd1, model_word(3'd2, 16'd1), "post clear");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
